fir_mac_sequencer: RTL



---
 rtl/fir_mac_sequencer_pkg.sv | 21 ++
 rtl/fir_mac_sequencer_if.sv | 37 +++
 rtl/fir_mac_sequencer_tick_gen.sv | 44 ++++
 rtl/fir_mac_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR MAC sequencer.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    MAC,
    DRAIN,
    DONE
  } seq_state_e;

  // ADDR_W = clog2(TAPS), CNT_W = clog2(DIV); functions so each instance sizes itself
  function automatic int addr_w(input int taps);
    return (taps <= 2) ? 1 : $clog2(taps);
  endfunction

  function automatic int cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Handshake bundle between the FIR sequencer (master) and the datapath/stimulus side (slave).
interface fir_mac_sequencer_if #(
  parameter int TAPS   = 16,
  parameter int DATA_W = 16
);
  import fir_pkg::*;

  localparam int AW = addr_w(TAPS);

  logic              en;
  logic [DATA_W-1:0] sample_in;
  logic              clr_ovr;
  logic              dl_wr_en;
  logic [AW-1:0]     dl_wr_addr;
  logic [DATA_W-1:0] dl_wr_data;
  logic [AW-1:0]     dl_rd_addr;
  logic [AW-1:0]     coef_addr;
  logic              acc_en;
  logic              acc_clr;
  logic              busy;
  logic              y_valid;
  logic              ovr;
  logic              clk_out;

  modport master (
    input  en, sample_in, clr_ovr,
    output dl_wr_en, dl_wr_addr, dl_wr_data, dl_rd_addr, coef_addr,
           acc_en, acc_clr, busy, y_valid, ovr, clk_out
  );

  modport slave (
    output en, sample_in, clr_ovr,
    input  dl_wr_en, dl_wr_addr, dl_wr_data, dl_rd_addr, coef_addr,
           acc_en, acc_clr, busy, y_valid, ovr, clk_out
  );

endinterface

// File: rtl/fir_mac_sequencer_tick_gen.sv
// Sample-rate divider: one-cycle tick every DIV enabled cycles.
// FIR_SEQ_CLKOUT_EN builds a clk_out flop that toggles on every tick.
module fir_tick_gen
  import fir_pkg::*;
#(
  parameter int DIV = 126
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic en_i,
  output logic tick_o,
  output logic clk_out_o
);

  localparam int CW = cnt_w(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = '0;
    if (en_i) cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

`ifdef FIR_SEQ_CLKOUT_EN
  logic clk_out_q;

  always_ff @(posedge clk_in) begin
    if (!reset_n)    clk_out_q <= 1'b0;
    else if (tick_o) clk_out_q <= ~clk_out_q;
  end

  assign clk_out_o = clk_out_q;
`else
  assign clk_out_o = 1'b0;
`endif

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one shared MAC over a circular delay line: capture, write, TAPS MACs, drain, strobe.
// Optional FIR_SEQ_CLKOUT_EN enables the clk_out square wave in fir_tick_gen.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS    = 16,
  parameter int DATA_W  = 16,
  parameter int DIV     = 126,
  parameter int MAC_LAT = 2
) (
  input  logic                clk_in,
  input  logic                reset_n,
  fir_mac_sequencer_if.master bus
);

  localparam int AW = addr_w(TAPS);
  localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  seq_state_e        state_q;
  logic [AW-1:0]     wptr_q, last_q, k_q;
  logic [AW-1:0]     wr_addr_q, rd_addr_q, coef_q;
  logic [LW-1:0]     drain_q;
  logic [DATA_W-1:0] sample_q;
  logic              wr_en_q, acc_en_q, acc_clr_q, busy_q, y_valid_q, ovr_q;
  logic              tick, clk_out;

  fir_tick_gen #(.DIV(DIV)) u_tick (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .en_i      (bus.en),
    .tick_o    (tick),
    .clk_out_o (clk_out)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      last_q    <= '0;
      k_q       <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      coef_q    <= '0;
      drain_q   <= '0;
      sample_q  <= '0;
      wr_en_q   <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      y_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      y_valid_q <= 1'b0;

      // a tick while busy (DONE included) is dropped; setting beats clearing
      if (tick && state_q != IDLE) ovr_q <= 1'b1;
      else if (bus.clr_ovr)        ovr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (tick) begin
            sample_q  <= bus.sample_in;
            wr_en_q   <= 1'b1;
            wr_addr_q <= wptr_q;
            busy_q    <= 1'b1;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          last_q    <= wptr_q;
          wptr_q    <= wptr_q + 1'b1;
          wr_addr_q <= '0;
          k_q       <= '0;
          acc_en_q  <= 1'b1;
          acc_clr_q <= 1'b1;
          coef_q    <= '0;
          rd_addr_q <= wptr_q;
          state_q   <= MAC;
        end
        MAC: begin
          if (k_q == AW'(TAPS - 1)) begin
            rd_addr_q <= '0;
            coef_q    <= '0;
            if (MAC_LAT == 0) begin
              y_valid_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              drain_q <= LW'(MAC_LAT - 1);
              state_q <= DRAIN;
            end
          end else begin
            k_q       <= k_q + 1'b1;
            acc_en_q  <= 1'b1;
            coef_q    <= k_q + 1'b1;
            rd_addr_q <= last_q - (k_q + 1'b1);
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            y_valid_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dl_wr_en   = wr_en_q;
  assign bus.dl_wr_addr = wr_addr_q;
  assign bus.dl_wr_data = sample_q;
  assign bus.dl_rd_addr = rd_addr_q;
  assign bus.coef_addr  = coef_q;
  assign bus.acc_en     = acc_en_q;
  assign bus.acc_clr    = acc_clr_q;
  assign bus.busy       = busy_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.ovr        = ovr_q;
  assign bus.clk_out    = clk_out;

endmodule
